// File: rtl/lsu.sv
// Load/store unit: one decoded memory request at a time onto a single-outstanding
// bus with byte strobes; returns extended load data with a one-cycle completion strobe.
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_bvalid,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // the requester holds req_valid and its fields stable until then.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic        wen_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic        resp_valid_q, resp_err_q, mem_req_q, mem_we_q;
    logic [31:0] resp_rdata_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic        legal_d;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_d;

    always_comb begin
        legal_d = 1'b0;
        strb_d  = 4'b1111;
        wdata_d = req_wdata;
        case (req_func3[1:0])
            2'd0: begin
                strb_d  = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_d  = 4'b0011 << req_addr[1:0];
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        // Width/sign legality first, then natural alignment of the access size.
        if (req_wen)
            legal_d = (req_func3 == 3'd0) || (req_func3 == 3'd1) || (req_func3 == 3'd2);
        else
            legal_d = (req_func3 != 3'd3) && (req_func3 != 3'd6) && (req_func3 != 3'd7);
        if (req_func3[1:0] == 2'd1 && req_addr[0])
            legal_d = 1'b0;
        if (req_func3[1:0] == 2'd2 && req_addr[1:0] != 2'b00)
            legal_d = 1'b0;

        shifted = mem_rdata >> {off_q, 3'b000};
        case (func3_q)
            3'd0:    load_d = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_d = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_d = {24'h0, shifted[7:0]};
            3'd5:    load_d = {16'h0, shifted[15:0]};
            default: load_d = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wen_q        <= 1'b0;
            func3_q      <= 3'd0;
            off_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        func3_q <= req_func3;
                        off_q   <= req_addr[1:0];
                        if (legal_d) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_wen;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb_q <= req_wen ? strb_d : 4'h0;
                            mem_wdata_q <= req_wen ? wdata_d : 32'h0;
                            state_q     <= S_REQ;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!wen_q && mem_rvalid) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_d;
                        state_q      <= S_RESP;
                    end else if (wen_q && mem_bvalid) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        state_q      <= S_RESP;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized operations against a byte-level
// memory model; the bench plays the bus slave and times every handshake.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_bvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [logic [29:0]];

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid),
        .dbg_state(dbg_state)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (mem_m.exists(a[31:2])) return mem_m[a[31:2]];
        return ({2'b00, a[31:2]} * 32'h9E3779B1) ^ 32'h5A5A0FF0;
    endfunction

    function automatic bit model_legal(input logic wen, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (wen && f3 > 3'd2) return 1'b0;
        if (!wen && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
        n = 1 << f3[1:0];
        return (a % n) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        int n;
        longint v;
        n = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < n; i++)
            v = v | (longint'((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input int off);
        logic [3:0] s;
        int n;
        n = 1 << f3[1:0];
        s = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_lanes(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] r;
        int n;
        n = 1 << f3[1:0];
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int n, off;
        n = 1 << f3[1:0];
        off = int'(a[1:0]);
        w = model_word(a);
        for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        mem_m[a[31:2]] = w;
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_wen   = 1'($urandom_range(0, 1));
        req_func3 = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_req(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output int waited, output bit ok);
        req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = a; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = req_ready;
        if (!ok) begin
            check32("accept_timeout", 32'(waited), 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        junk_req();
    endtask

    task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rd,
                          output logic [31:0] got_rdata, output logic [3:0] got_strb,
                          output logic [31:0] got_wdata, output int waited);
        bit ok;
        logic [31:0] exp_rd;
        got_rdata = 32'hx; got_strb = 4'hx; got_wdata = 32'hx;
        send_req(wen, f3, a, wd, waited, ok);
        if (!ok) return;
        if (!model_legal(wen, f3, a)) begin
            check32("err_valid", 32'(resp_valid), 32'd1);
            check32("err_flag", 32'(resp_err), 32'd1);
            check32("err_rdata", resp_rdata, 32'h0);
            check32("err_no_req", 32'(mem_req), 32'd0);
            got_rdata = resp_rdata;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check32("err_pulse_end", 32'(resp_valid), 32'd0);
            check32("err_no_req2", 32'(mem_req), 32'd0);
            check32("err_ready", 32'(req_ready), 32'd1);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            check32("req_held", 32'(mem_req), 32'd1);
            check32("req_no_resp", 32'(resp_valid), 32'd0);
            if (k == 0) begin
                got_strb = mem_wstrb;
                got_wdata = mem_wdata;
                check32("bus_addr", mem_addr, {a[31:2], 2'b00});
                check32("bus_we", 32'(mem_we), 32'(wen));
                check32("bus_strb", 32'(mem_wstrb), wen ? 32'(exp_strb(f3, int'(a[1:0]))) : 32'd0);
                if (wen) check32("bus_wdata", mem_wdata, exp_lanes(wd, f3));
            end
            mem_gnt = (k == gd);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_bvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            junk_req();
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
        exp_rd = wen ? 32'h0 : exp_load(model_word(a), f3, int'(a[1:0]));
        for (int k = 0; k <= rd; k++) begin
            check32("wait_no_req", 32'(mem_req), 32'd0);
            check32("wait_no_resp", 32'(resp_valid), 32'd0);
            if (wen) begin
                mem_bvalid = (k == rd);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end else begin
                mem_rvalid = (k == rd);
                mem_bvalid = 1'($urandom_range(0, 1));
                mem_rdata = (k == rd) ? model_word(a) : $urandom;
            end
            junk_req();
            @(posedge clk); #1;
            if (wen && k == rd) model_store(a, f3, wd);
        end
        mem_rvalid = 1'b0; mem_bvalid = 1'b0; mem_rdata = $urandom;
        check32("resp_valid", 32'(resp_valid), 32'd1);
        check32("resp_err", 32'(resp_err), 32'd0);
        check32("resp_rdata", resp_rdata, exp_rd);
        got_rdata = resp_rdata;
        junk_req();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check32("resp_pulse_end", 32'(resp_valid), 32'd0);
        check32("resp_rdata_hold", resp_rdata, exp_rd);
        check32("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rdv, wdv, sw_data;
        logic [3:0]  sv;
        int waited;
        bit ok;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_bvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_ready", 32'(req_ready), 32'd0);
        check32("rst_resp_valid", 32'(resp_valid), 32'd0);
        check32("rst_resp_err", 32'(resp_err), 32'd0);
        check32("rst_rdata", resp_rdata, 32'h0);
        check32("rst_mem_req", 32'(mem_req), 32'd0);
        check32("rst_mem_we", 32'(mem_we), 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        #1;
        check32("ready_out_of_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        mem_m[30'h20000001] = 32'hDEADBEEF;
        run_op(1'b0, 3'd2, 32'h80000004, 32'h0, 0, 0, rdv, sv, wdv, waited);
        check32("lw_value", rdv, 32'hDEADBEEF);
        check32("lw_strb", 32'(sv), 32'd0);

        mem_m[30'h20000000] = 32'h80FF7F01;
        run_op(1'b0, 3'd0, 32'h80000003, 32'h0, 0, 0, rdv, sv, wdv, waited);
        check32("lb_value", rdv, 32'hFFFFFF80);
        run_op(1'b0, 3'd4, 32'h80000003, 32'h0, 1, 0, rdv, sv, wdv, waited);
        check32("lbu_value", rdv, 32'h00000080);
        run_op(1'b0, 3'd1, 32'h80000002, 32'h0, 0, 1, rdv, sv, wdv, waited);
        check32("lh_value", rdv, 32'hFFFF80FF);

        run_op(1'b1, 3'd0, 32'h80000001, 32'h123456AB, 3, 2, rdv, sv, wdv, waited);
        check32("sb_strb", 32'(sv), 32'b0010);
        check32("sb_wdata", wdv, 32'hABABABAB);
        check32("sb_rdata", rdv, 32'h0);

        run_op(1'b0, 3'd2, 32'h80000002, 32'h0, 0, 0, rdv, sv, wdv, waited);
        run_op(1'b1, 3'd1, 32'h80000003, 32'h5555AAAA, 0, 0, rdv, sv, wdv, waited);
        run_op(1'b0, 3'd3, 32'h80000000, 32'h0, 0, 0, rdv, sv, wdv, waited);

        sw_data = $urandom;
        run_op(1'b1, 3'd2, 32'h80000020, sw_data, 0, 0, rdv, sv, wdv, waited);
        run_op(1'b0, 3'd2, 32'h80000020, 32'h0, 0, 0, rdv, sv, wdv, waited);
        check32("b2b_accept_gap", 32'(waited), 32'd0);
        check32("b2b_load_value", rdv, sw_data);

        // Reset pulsed while a load waits for read data, then a stray rvalid.
        send_req(1'b0, 3'd2, 32'h80000004, 32'h0, waited, ok);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check32("mid_rst_ready", 32'(req_ready), 32'd0);
        check32("mid_rst_valid", 32'(resp_valid), 32'd0);
        check32("mid_rst_rdata", resp_rdata, 32'h0);
        check32("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check32("mid_rst_addr", mem_addr, 32'h0);
        check32("mid_rst_strb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check32("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check32("stray_no_resp", 32'(resp_valid), 32'd0);
        check32("stray_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check32("stray_no_resp2", 32'(resp_valid), 32'd0);
        run_op(1'b0, 3'd2, 32'h80000004, 32'h0, 1, 1, rdv, sv, wdv, waited);
        check32("after_rst_lw", rdv, 32'hDEADBEEF);

        for (int t = 0; t < 80; t++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h80000000 + $urandom_range(0, 63), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), rdv, sv, wdv, waited);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

The load/store unit executes the memory operations the instruction decoder flags (loads `0000011`, stores `0100011`). It takes one decoded request (store flag, func3, effective address, store data) through a valid/ready handshake and drives a single-outstanding memory bus with byte strobes. It returns sign- or zero-extended load data to the register write-back path, pulsing a completion strobe so the core can stall while it is busy. It sits between the execute stage and data memory.

## Interface
- `ADDR_W`, 32, address width; data width is fixed at 32.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  decoded memory operation present.
- `req_ready`  out  1  LSU idle; request accepted on `req_valid && req_ready`.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_func3`  in  3  RV32I width/sign field (inst[14:12]).
- `req_addr`  in  ADDR_W  effective address (rs1 + imm).
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle pulse: operation finished.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: misaligned or illegal func3.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  ADDR_W  word-aligned address (`req_addr` with [1:0] = 0).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0 for loads.
- `mem_gnt`  in  1  bus accepts request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data word.
- `mem_bvalid`  in  1  write acknowledged.

## Operation
- States: IDLE, REQ, WAIT, RESP. `req_ready` = (state == IDLE) && !rst.
- IDLE: on accept, latch wen, func3, addr[1:0], and the bus fields. Check legality:
  - loads: func3 ∈ {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU};
  - stores: func3 ∈ {0 SB, 1 SH, 2 SW};
  - halfword needs addr[0] = 0; word needs addr[1:0] = 0.
- Illegal request: go to RESP with `resp_err` = 1; no bus activity.
- Legal request: go to REQ.
- REQ: `mem_req` = 1, with bus fields held stable. On `mem_gnt` go to WAIT. `mem_rvalid`/`mem_bvalid` are ignored in REQ.
- WAIT: `mem_req` = 0.
  - Load: on `mem_rvalid`, capture the extended data and go to RESP.
  - Store: on `mem_bvalid`, go to RESP.
  - The other response signal is ignored.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE.
- `resp_rdata` and `resp_err` stay stable until the next RESP.
- Store strobes, with o = addr[1:0]:
  - SB: `4'b0001 << o`, wdata = {4{wdata[7:0]}};
  - SH: `4'b0011 << o`, wdata = {2{wdata[15:0]}};
  - SW: `4'b1111`, wdata unchanged.
- Load extract: s = `mem_rdata >> (8*o)`.
  - LB = sext(s[7:0]); LBU = zext(s[7:0]).
  - LH = sext(s[15:0]); LHU = zext(s[15:0]).
  - LW = `mem_rdata`.

## Timing
- Reset: state IDLE; `req_ready`, `resp_valid`, `resp_err`, `mem_req`, `mem_we` = 0; `resp_rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0.
- All outputs are registered or decoded from state only. No combinational path from `mem_*` inputs to `mem_*` outputs.
- Accept at cycle 0. `mem_req` is high from cycle 1 until and including the `mem_gnt` cycle.
- Best case (gnt at cycle 1, rvalid/bvalid at cycle 2): `resp_valid` at cycle 3, `req_ready` at cycle 4. Throughput is one operation per 4 cycles.
- Illegal request: `resp_valid` at cycle 1, no `mem_req`.
- Each wait cycle of gnt or response adds one cycle of latency. There is no timeout.
- `rst` in any state: next cycle is IDLE with all outputs at reset values.
  - An in-flight bus transaction is abandoned.
  - Late `mem_rvalid`/`mem_bvalid` seen in IDLE are ignored and produce no `resp_valid`.
- `req_valid` while busy is not accepted. The requester holds it.

## Test plan
- LW addr 0x80000004, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF -> `mem_addr` 0x80000004, `mem_wstrb` 0; `resp_valid` at cycle 3 with rdata 0xDEADBEEF, err 0.
- LB / LBU addr 0x80000003, rdata 0x80FF7F01 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr offset 2 gives 0xFFFF80FF.
- SB addr 0x80000001, wdata 0x123456AB, gnt delayed 3 cycles, bvalid 2 cycles later -> `mem_wstrb` 0010, `mem_wdata` 0xABABABAB, `mem_req` held 4 cycles, one `resp_valid` with rdata 0.
- LW addr 0x80000002; SH addr 0x80000003; load func3 = 3 -> each gives `resp_valid` + `resp_err` at cycle 1, `mem_req` never asserted.
- Back-to-back: SW then LW to the same word with `req_valid` held -> second accept exactly 1 cycle after the first `resp_valid`; the load returns the stored word from the memory model.
- `rst` pulsed in WAIT during a load, then a stray `mem_rvalid` -> outputs at reset values, no `resp_valid`, `req_ready` = 1 after `rst` drops; the next request completes normally.
